pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_src_sel.sv | 21 ++
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy encoding
// and the "not a register" source-index sentinel.
package pipe_pkg;

    // Number of entries held by the stage; the encoding doubles as the occ output.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    // Widest index the sentinel helper can produce.
    localparam int IDX_W_MAX = 32;

    // All-ones value of width w (low w bits set), used to mark an operand
    // that comes from an immediate or the PC rather than the register file.
    function automatic logic [IDX_W_MAX-1:0] idx_none(input int w);
        logic [IDX_W_MAX-1:0] v;
        v = '0;
        for (int b = 0; b < IDX_W_MAX; b++) begin
            if (b < w) begin
                v[b] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_src_sel.sv
// Per-operand sentinel mux: replaces a source index with all-ones when the
// operand is not a register, so downstream hazard logic never matches it.
module pipe_src_sel #(
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] src_idx,
    input  logic             src_nreg,
    output logic [IDX_W-1:0] sel_idx
);
    import pipe_pkg::*;

    logic [IDX_W-1:0] sentinel;

    assign sentinel = IDX_W'(idx_none(IDX_W));

    // Substitute the sentinel for non-register operands.
    always_comb begin
        sel_idx = src_nreg ? sentinel : src_idx;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register. The main entry drives
// the outputs; the skid entry absorbs one extra entry while downstream
// stalls, so in_ready can come straight from a flop.
module pipe_stage_reg #(
    parameter int PAY_W   = 140,
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAY_W-1:0]         in_pay,
    input  logic [NUM_SRC*IDX_W-1:0] in_src_idx,
    input  logic [NUM_SRC-1:0]       in_src_nreg,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAY_W-1:0]         out_pay,
    output logic [NUM_SRC*IDX_W-1:0] out_src_idx,
    output logic [1:0]               occ
);
    import pipe_pkg::*;

    localparam int SRC_W = NUM_SRC * IDX_W;

    occ_state_t       state_reg, state_next;
    logic [PAY_W-1:0] main_pay_reg, main_pay_next;
    logic [SRC_W-1:0] main_idx_reg, main_idx_next;
    logic [PAY_W-1:0] skid_pay_reg, skid_pay_next;
    logic [SRC_W-1:0] skid_idx_reg, skid_idx_next;
    logic             in_ready_reg, in_ready_next;

    logic [SRC_W-1:0] cap_idx;
    logic             in_xfer;
    logic             out_xfer;

    // Sentinel substitution happens before capture, so storage only ever
    // holds the substituted indices.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src_sel
            pipe_src_sel #(
                .IDX_W (IDX_W)
            ) u_src_sel (
                .src_idx  (in_src_idx[gi*IDX_W +: IDX_W]),
                .src_nreg (in_src_nreg[gi]),
                .sel_idx  (cap_idx[gi*IDX_W +: IDX_W])
            );
        end
    endgenerate

    assign out_valid = (state_reg != OCC_EMPTY);
    assign in_ready  = in_ready_reg;
    assign occ       = 2'(state_reg);

    // A flush cancels any input transfer in the same cycle; an output
    // transfer still completes because the consumer has taken the entry.
    assign in_xfer  = in_valid && in_ready_reg && !flush;
    assign out_xfer = out_valid && out_ready;

    // Occupancy transitions and entry movement between main and skid.
    always_comb begin
        state_next    = state_reg;
        main_pay_next = main_pay_reg;
        main_idx_next = main_idx_reg;
        skid_pay_next = skid_pay_reg;
        skid_idx_next = skid_idx_reg;

        case (state_reg)
            OCC_EMPTY: begin
                if (in_xfer) begin
                    state_next    = OCC_ONE;
                    main_pay_next = in_pay;
                    main_idx_next = cap_idx;
                end
            end
            OCC_ONE: begin
                if (in_xfer && out_xfer) begin
                    // Main drains and refills in the same edge.
                    main_pay_next = in_pay;
                    main_idx_next = cap_idx;
                end else if (in_xfer) begin
                    state_next    = OCC_TWO;
                    skid_pay_next = in_pay;
                    skid_idx_next = cap_idx;
                end else if (out_xfer) begin
                    state_next    = OCC_EMPTY;
                    main_pay_next = '0;
                    main_idx_next = '0;
                end
            end
            OCC_TWO: begin
                // in_ready is low here, so only the output side can move.
                if (out_xfer) begin
                    state_next    = OCC_ONE;
                    main_pay_next = skid_pay_reg;
                    main_idx_next = skid_idx_reg;
                    skid_pay_next = '0;
                    skid_idx_next = '0;
                end
            end
            default: begin
                // Unused encoding: recover to a clean empty stage.
                state_next    = OCC_EMPTY;
                main_pay_next = '0;
                main_idx_next = '0;
                skid_pay_next = '0;
                skid_idx_next = '0;
            end
        endcase

        if (flush) begin
            state_next    = OCC_EMPTY;
            main_pay_next = '0;
            main_idx_next = '0;
            skid_pay_next = '0;
            skid_idx_next = '0;
        end

        // Registered ready: high whenever the next state still has room.
        in_ready_next = (state_next != OCC_TWO);
    end

    // State, storage and ready registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= OCC_EMPTY;
            main_pay_reg <= '0;
            main_idx_reg <= '0;
            skid_pay_reg <= '0;
            skid_idx_reg <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            main_pay_reg <= main_pay_next;
            main_idx_reg <= main_idx_next;
            skid_pay_reg <= skid_pay_next;
            skid_idx_reg <= skid_idx_next;
            in_ready_reg <= in_ready_next;
        end
    end

    // Present a zero bubble whenever nothing valid is held.
    always_comb begin
        out_pay     = out_valid ? main_pay_reg : '0;
        out_src_idx = out_valid ? main_idx_reg : '0;
    end

endmodule
